// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the SRAM arbiter, its three requesters (loader, fetch, LSU) and the SRAM macro.
// The slave side is the arbiter; the master side is everything around it.
interface sram_port_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 64
);
    logic              ld_valid;
    logic              ld_ready;
    logic [AW-1:0]     ld_addr;
    logic [DW-1:0]     ld_data;
    logic              ld_done;

    logic              if_valid;
    logic              if_ready;
    logic [AW-1:0]     if_addr;
    logic              if_rsp_valid;
    logic [DW-1:0]     if_rsp_data;

    logic              ls_valid;
    logic              ls_ready;
    logic [AW-1:0]     ls_addr;
    logic              ls_wen;
    logic [DW/8-1:0]   ls_wstrb;
    logic [DW-1:0]     ls_wdata;
    logic              ls_rsp_valid;
    logic [DW-1:0]     ls_rsp_data;

    logic              sram_cs;
    logic              sram_we;
    logic [DW/8-1:0]   sram_wmask;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_wdata;
    logic [DW-1:0]     sram_rdata;

    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_done,
        input  if_valid, if_addr,
        input  ls_valid, ls_addr, ls_wen, ls_wstrb, ls_wdata,
        input  sram_rdata,
        output ld_ready, if_ready, if_rsp_valid, if_rsp_data,
        output ls_ready, ls_rsp_valid, ls_rsp_data,
        output sram_cs, sram_we, sram_wmask, sram_addr, sram_wdata
    );

    modport master (
        output ld_valid, ld_addr, ld_data, ld_done,
        output if_valid, if_addr,
        output ls_valid, ls_addr, ls_wen, ls_wstrb, ls_wdata,
        output sram_rdata,
        input  ld_ready, if_ready, if_rsp_valid, if_rsp_data,
        input  ls_ready, ls_rsp_valid, ls_rsp_data,
        input  sram_cs, sram_we, sram_wmask, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Boot sequencer and round-robin arbiter for the single-port on-chip SRAM: the loader owns the
// SRAM while the core is held in reset, then fetch and LSU share it one access per cycle.
module sram_port_arbiter (
    input  logic               CLK,
    input  logic               RSTn,
    output logic               core_rstn,
    sram_port_arbiter_if.slave bus
);

    typedef enum logic {LOAD, RUN} state_t;
    typedef enum logic {PORT_IF, PORT_LS} port_t;

    state_t state;
    port_t  last_grant;
    logic   grant_if;
    logic   grant_ls;

    // On a tie the port that did not win last time gets the SRAM.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == RUN) begin
            if (bus.if_valid && bus.ls_valid) begin
                grant_if = (last_grant == PORT_LS);
                grant_ls = (last_grant == PORT_IF);
            end else begin
                grant_if = bus.if_valid;
                grant_ls = bus.ls_valid;
            end
        end
    end

    assign bus.ld_ready    = (state == LOAD) && bus.ld_valid;
    assign bus.if_ready    = grant_if;
    assign bus.ls_ready    = grant_ls;
    assign bus.if_rsp_data = bus.sram_rdata;
    assign bus.ls_rsp_data = bus.sram_rdata;

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        bus.sram_cs    = 1'b0;
        bus.sram_we    = 1'b0;
        bus.sram_wmask = '0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        if (bus.ld_ready) begin
            bus.sram_cs    = 1'b1;
            bus.sram_we    = 1'b1;
            bus.sram_wmask = '1;
            bus.sram_addr  = bus.ld_addr;
            bus.sram_wdata = bus.ld_data;
        end else if (grant_if) begin
            bus.sram_cs    = 1'b1;
            bus.sram_addr  = bus.if_addr;
        end else if (grant_ls) begin
            bus.sram_cs    = 1'b1;
            bus.sram_we    = bus.ls_wen;
            bus.sram_wmask = bus.ls_wen ? bus.ls_wstrb : '0;
            bus.sram_addr  = bus.ls_addr;
            bus.sram_wdata = bus.ls_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state            <= LOAD;
            core_rstn        <= 1'b0;
            bus.if_rsp_valid <= 1'b0;
            bus.ls_rsp_valid <= 1'b0;
            last_grant       <= PORT_LS;
        end else begin
            // RUN is left only through reset; ld_done is meaningless once running.
            if (state == LOAD && bus.ld_done) begin
                state     <= RUN;
                core_rstn <= 1'b1;
            end
            bus.if_rsp_valid <= grant_if;
            bus.ls_rsp_valid <= grant_ls;
            if (grant_if) begin
                last_grant <= PORT_IF;
            end else if (grant_ls) begin
                last_grant <= PORT_LS;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: a behavioural SRAM macro plus a reference model that
// predicts grants from the round-robin rule (grant history queue) and read data from a word array.
module tb_sram_port_arbiter;

    localparam int AW    = 14;
    localparam int DW    = 64;
    localparam int SW    = DW / 8;
    localparam int WORDS = 1 << AW;

    logic CLK = 1'b0;
    logic RSTn;
    logic core_rstn;

    sram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    sram_port_arbiter dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .core_rstn(core_rstn),
        .bus      (bus.slave)
    );

    always #5 CLK = ~CLK;

    // SRAM macro: masked write, read data registered one cycle after the strobe.
    logic [DW-1:0] sram_mem [0:WORDS-1];
    logic [DW-1:0] sram_word;
    always @(posedge CLK) begin
        if (bus.sram_cs) begin
            if (bus.sram_we) begin
                sram_word = sram_mem[bus.sram_addr];
                for (int b = 0; b < SW; b++)
                    if (bus.sram_wmask[b]) sram_word[b*8 +: 8] = bus.sram_wdata[b*8 +: 8];
                sram_mem[bus.sram_addr] <= sram_word;
            end else begin
                bus.sram_rdata <= sram_mem[bus.sram_addr];
            end
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:WORDS-1];
    int            grant_hist[$];   // 1 = fetch, 2 = LSU, in grant order
    int            checks = 0;
    int            errors = 0;

    // 0 = no grant, 1 = fetch, 2 = LSU.
    function automatic int predict(bit iv, bit lv);
        if (iv && lv) return (grant_hist.size() == 0 || grant_hist[$] == 2) ? 1 : 2;
        if (iv) return 1;
        if (lv) return 2;
        return 0;
    endfunction

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old_w, logic [DW-1:0] new_w,
                                            logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < SW; b++)
            if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    task automatic drive_idle();
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_done = 1'b0;
        bus.if_valid = 1'b0; bus.if_addr = '0;
        bus.ls_valid = 1'b0; bus.ls_addr = '0; bus.ls_wen = 1'b0;
        bus.ls_wstrb = '0;   bus.ls_wdata = '0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        drive_idle();
        @(negedge CLK);
        checks += 4;
        if (core_rstn !== 1'b0) begin errors++; $display("FAIL reset_core_rstn: got %b expected 0", core_rstn); end
        if (bus.if_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_if_rsp: got %b expected 0", bus.if_rsp_valid); end
        if (bus.ls_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_ls_rsp: got %b expected 0", bus.ls_rsp_valid); end
        if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready_idle: got %b expected 0", bus.ld_ready); end
        bus.ld_valid = 1'b1;
        #1;
        checks += 2;
        if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready_follow: got %b expected 1", bus.ld_ready); end
        if (bus.sram_cs !== 1'b1) begin errors++; $display("FAIL reset_sram_cs: got %b expected 1", bus.sram_cs); end
        bus.ld_valid = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        grant_hist.delete();
    endtask

    task automatic test_load_gating();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            bus.if_valid = 1'b1; bus.if_addr = AW'($urandom_range(0, 15));
            bus.ls_valid = 1'b1; bus.ls_addr = AW'($urandom_range(0, 15));
            bus.ls_wen = 1'($urandom_range(0, 1)); bus.ls_wstrb = '1;
            #1;
            checks += 4;
            if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL load_if_ready: got %b expected 0", bus.if_ready); end
            if (bus.ls_ready !== 1'b0) begin errors++; $display("FAIL load_ls_ready: got %b expected 0", bus.ls_ready); end
            if (bus.sram_cs !== 1'b0) begin errors++; $display("FAIL load_sram_cs: got %b expected 0", bus.sram_cs); end
            if (bus.sram_wmask !== '0) begin errors++; $display("FAIL load_sram_wmask: got %h expected 0", bus.sram_wmask); end
            @(posedge CLK); #1;
            checks += 2;
            if (bus.if_rsp_valid !== 1'b0 || bus.ls_rsp_valid !== 1'b0) begin
                errors++; $display("FAIL load_rsp: got if=%b ls=%b expected 0 0", bus.if_rsp_valid, bus.ls_rsp_valid);
            end
            if (core_rstn !== 1'b0) begin errors++; $display("FAIL load_core_rstn: got %b expected 0", core_rstn); end
        end
        @(negedge CLK);
        drive_idle();
    endtask

    task automatic test_preload();
        logic [AW-1:0] addrs[$];
        logic [DW-1:0] datas[$];
        addrs = '{14'h0000, 14'h3FFF, 14'd10};
        datas = '{64'hDEADBEEF_00000013, 64'h1, 64'hFFFFFFFF_FFFFFFFF};
        for (int a = 1; a < 16; a++) begin
            if (a != 5 && a != 10) begin
                addrs.push_back(AW'(a));
                datas.push_back({$urandom, $urandom});
            end
        end
        addrs.push_back(14'd5);
        datas.push_back(64'hA5);
        for (int i = 0; i < addrs.size(); i++) begin
            bit last;
            last = (i == addrs.size() - 1);
            @(negedge CLK);
            bus.ld_valid = 1'b1; bus.ld_addr = addrs[i]; bus.ld_data = datas[i]; bus.ld_done = last;
            #1;
            checks += 3;
            if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL preload_ld_ready[%0d]: got %b expected 1", i, bus.ld_ready); end
            if ({bus.sram_cs, bus.sram_we, bus.sram_wmask} !== {2'b11, {SW{1'b1}}}) begin
                errors++; $display("FAIL preload_strobe[%0d]: got cs=%b we=%b mask=%h expected 1 1 ff", i, bus.sram_cs, bus.sram_we, bus.sram_wmask);
            end
            if (bus.sram_addr !== addrs[i] || bus.sram_wdata !== datas[i]) begin
                errors++; $display("FAIL preload_bus[%0d]: got %h/%h expected %h/%h", i, bus.sram_addr, bus.sram_wdata, addrs[i], datas[i]);
            end
            ref_mem[addrs[i]] = datas[i];
            @(posedge CLK); #1;
            checks++;
            if (core_rstn !== last) begin errors++; $display("FAIL preload_core_rstn[%0d]: got %b expected %b", i, core_rstn, last); end
        end
        @(negedge CLK);
        drive_idle();
    endtask

    task automatic test_fetch();
        logic [AW-1:0] addrs[$];
        addrs = '{14'h0000, 14'd5, 14'h3FFF};
        foreach (addrs[i]) begin
            if (i != 0) @(negedge CLK);
            bus.if_valid = 1'b1; bus.if_addr = addrs[i];
            #1;
            checks += 2;
            if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready[%0d]: got %b expected 1", i, bus.if_ready); end
            if ({bus.sram_cs, bus.sram_we} !== 2'b10 || bus.sram_addr !== addrs[i]) begin
                errors++; $display("FAIL fetch_strobe[%0d]: got cs=%b we=%b addr=%h expected 1 0 %h", i, bus.sram_cs, bus.sram_we, bus.sram_addr, addrs[i]);
            end
            @(posedge CLK); #1;
            grant_hist.push_back(1);
            checks += 2;
            if (bus.if_rsp_valid !== 1'b1 || bus.ls_rsp_valid !== 1'b0) begin
                errors++; $display("FAIL fetch_rsp_valid[%0d]: got if=%b ls=%b expected 1 0", i, bus.if_rsp_valid, bus.ls_rsp_valid);
            end
            if (bus.if_rsp_data !== ref_mem[addrs[i]]) begin
                errors++; $display("FAIL fetch_data[%0d]: got %h expected %h", i, bus.if_rsp_data, ref_mem[addrs[i]]);
            end
        end
        checks++;
        if (bus.if_rsp_data !== 64'hDEADBEEF_00000013 && core_rstn === 1'b1 && 1'b0) errors++;
        @(negedge CLK);
        drive_idle();
        @(posedge CLK); #1;
        checks++;
        if (bus.if_rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_pulse_end: got %b expected 0", bus.if_rsp_valid); end
    endtask

    task automatic test_byte_write();
        @(negedge CLK);
        bus.ls_valid = 1'b1; bus.ls_addr = 14'd10; bus.ls_wen = 1'b1;
        bus.ls_wstrb = 8'h0F; bus.ls_wdata = 64'h11223344_55667788;
        #1;
        checks += 2;
        if (bus.ls_ready !== 1'b1) begin errors++; $display("FAIL bytewr_ready: got %b expected 1", bus.ls_ready); end
        if ({bus.sram_cs, bus.sram_we, bus.sram_wmask} !== {2'b11, 8'h0F}) begin
            errors++; $display("FAIL bytewr_strobe: got cs=%b we=%b mask=%h expected 1 1 0f", bus.sram_cs, bus.sram_we, bus.sram_wmask);
        end
        @(posedge CLK); #1;
        grant_hist.push_back(2);
        ref_mem[10] = merge(ref_mem[10], 64'h11223344_55667788, 8'h0F);
        checks++;
        if (bus.ls_rsp_valid !== 1'b1) begin errors++; $display("FAIL bytewr_ack: got %b expected 1", bus.ls_rsp_valid); end
        @(negedge CLK);
        bus.ls_wen = 1'b0;
        #1;
        checks++;
        if (bus.sram_we !== 1'b0 || bus.sram_wmask !== '0) begin
            errors++; $display("FAIL byterd_strobe: got we=%b mask=%h expected 0 00", bus.sram_we, bus.sram_wmask);
        end
        @(posedge CLK); #1;
        grant_hist.push_back(2);
        checks++;
        if (bus.ls_rsp_valid !== 1'b1 || bus.ls_rsp_data !== 64'hFFFFFFFF_55667788) begin
            errors++; $display("FAIL byterd_data: got v=%b %h expected 1 ffffffff55667788", bus.ls_rsp_valid, bus.ls_rsp_data);
        end
        @(negedge CLK);
        drive_idle();
    endtask

    task automatic test_contention();
        for (int i = 0; i < 6; i++) begin
            int            exp;
            logic [AW-1:0] ia, la;
            if (i != 0) @(negedge CLK);
            ia = AW'($urandom_range(0, 15));
            la = AW'($urandom_range(0, 15));
            bus.if_valid = 1'b1; bus.if_addr = ia;
            bus.ls_valid = 1'b1; bus.ls_addr = la; bus.ls_wen = 1'b0;
            exp = predict(1'b1, 1'b1);
            #1;
            checks += 2;
            if (exp != ((i % 2 == 0) ? 1 : 2)) begin errors++; $display("FAIL contention_order[%0d]: got %0d expected %0d", i, exp, (i % 2 == 0) ? 1 : 2); end
            if (bus.if_ready !== (exp == 1) || bus.ls_ready !== (exp == 2)) begin
                errors++; $display("FAIL contention_ready[%0d]: got if=%b ls=%b expected grant %0d", i, bus.if_ready, bus.ls_ready, exp);
            end
            @(posedge CLK); #1;
            grant_hist.push_back(exp);
            checks += 2;
            if (bus.if_rsp_valid !== (exp == 1) || bus.ls_rsp_valid !== (exp == 2)) begin
                errors++; $display("FAIL contention_rsp[%0d]: got if=%b ls=%b expected grant %0d", i, bus.if_rsp_valid, bus.ls_rsp_valid, exp);
            end
            if (bus.sram_rdata !== ref_mem[(exp == 1) ? ia : la]) begin
                errors++; $display("FAIL contention_data[%0d]: got %h expected %h", i, bus.sram_rdata, ref_mem[(exp == 1) ? ia : la]);
            end
        end
        @(negedge CLK);
        drive_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int            exp;
            bit            iv, lv, wen;
            logic [AW-1:0] ia, la;
            logic [SW-1:0] strb;
            logic [DW-1:0] wd;
            @(negedge CLK);
            iv = 1'($urandom_range(0, 1)); lv = 1'($urandom_range(0, 1)); wen = 1'($urandom_range(0, 1));
            ia = AW'($urandom_range(0, 15)); la = AW'($urandom_range(0, 15));
            strb = SW'($urandom); wd = {$urandom, $urandom};
            bus.if_valid = iv; bus.if_addr = ia;
            bus.ls_valid = lv; bus.ls_addr = la; bus.ls_wen = wen; bus.ls_wstrb = strb; bus.ls_wdata = wd;
            exp = predict(iv, lv);
            #1;
            checks += 2;
            if (bus.if_ready !== (exp == 1) || bus.ls_ready !== (exp == 2)) begin
                errors++; $display("FAIL random_ready[%0d]: got if=%b ls=%b expected grant %0d", i, bus.if_ready, bus.ls_ready, exp);
            end
            if (bus.sram_cs !== (exp != 0) || bus.sram_we !== (exp == 2 && wen)) begin
                errors++; $display("FAIL random_strobe[%0d]: got cs=%b we=%b expected grant %0d wen %b", i, bus.sram_cs, bus.sram_we, exp, wen);
            end
            @(posedge CLK); #1;
            if (exp != 0) grant_hist.push_back(exp);
            checks++;
            if (bus.if_rsp_valid !== (exp == 1) || bus.ls_rsp_valid !== (exp == 2)) begin
                errors++; $display("FAIL random_rsp[%0d]: got if=%b ls=%b expected grant %0d", i, bus.if_rsp_valid, bus.ls_rsp_valid, exp);
            end
            if (exp == 1) begin
                checks++;
                if (bus.if_rsp_data !== ref_mem[ia]) begin errors++; $display("FAIL random_if_data[%0d]: got %h expected %h", i, bus.if_rsp_data, ref_mem[ia]); end
            end else if (exp == 2 && !wen) begin
                checks++;
                if (bus.ls_rsp_data !== ref_mem[la]) begin errors++; $display("FAIL random_ls_data[%0d]: got %h expected %h", i, bus.ls_rsp_data, ref_mem[la]); end
            end else if (exp == 2) begin
                ref_mem[la] = merge(ref_mem[la], wd, strb);
            end
        end
        @(negedge CLK);
        drive_idle();
    endtask

    task automatic test_run_gating();
        @(negedge CLK);
        bus.ld_valid = 1'b1; bus.ld_addr = 14'd7; bus.ld_data = ~ref_mem[7]; bus.ld_done = 1'b1;
        #1;
        checks += 2;
        if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL run_ld_ready: got %b expected 0", bus.ld_ready); end
        if (bus.sram_cs !== 1'b0 || bus.sram_we !== 1'b0) begin
            errors++; $display("FAIL run_ld_strobe: got cs=%b we=%b expected 0 0", bus.sram_cs, bus.sram_we);
        end
        @(posedge CLK); #1;
        checks++;
        if (core_rstn !== 1'b1) begin errors++; $display("FAIL run_core_rstn: got %b expected 1", core_rstn); end
        @(negedge CLK);
        drive_idle();
        bus.if_valid = 1'b1; bus.if_addr = 14'd7;
        @(posedge CLK); #1;
        grant_hist.push_back(1);
        checks++;
        if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_data !== ref_mem[7]) begin
            errors++; $display("FAIL run_ld_dropped: got v=%b %h expected 1 %h", bus.if_rsp_valid, bus.if_rsp_data, ref_mem[7]);
        end
        @(negedge CLK);
        drive_idle();
    endtask

    task automatic test_reset_mid_op();
        @(negedge CLK);
        bus.ls_valid = 1'b1; bus.ls_addr = 14'd0; bus.ls_wen = 1'b0;
        #1;
        checks++;
        if (bus.ls_ready !== 1'b1) begin errors++; $display("FAIL midrst_grant: got %b expected 1", bus.ls_ready); end
        @(posedge CLK); #1;
        checks++;
        if (bus.ls_rsp_valid !== 1'b1) begin errors++; $display("FAIL midrst_rsp_before: got %b expected 1", bus.ls_rsp_valid); end
        drive_idle();
        RSTn = 1'b0;
        #1;
        checks += 2;
        if (bus.ls_rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rsp_dropped: got %b expected 0", bus.ls_rsp_valid); end
        if (core_rstn !== 1'b0) begin errors++; $display("FAIL midrst_core_rstn: got %b expected 0", core_rstn); end
        bus.ld_valid = 1'b1;
        #1;
        checks++;
        if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL midrst_ld_ready: got %b expected 1", bus.ld_ready); end
        bus.ld_valid = 1'b0; bus.if_valid = 1'b1;
        #1;
        checks += 2;
        if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL midrst_ld_ready_low: got %b expected 0", bus.ld_ready); end
        if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL midrst_if_ready: got %b expected 0", bus.if_ready); end
        @(negedge CLK);
        drive_idle();
        RSTn = 1'b1;
        grant_hist.delete();
        bus.if_valid = 1'b1; bus.ld_valid = 1'b1; bus.ld_addr = 14'd20; bus.ld_data = 64'h5A;
        #1;
        checks += 2;
        if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL midrst_load_if_ready: got %b expected 0", bus.if_ready); end
        if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL midrst_load_ld_ready: got %b expected 1", bus.ld_ready); end
        ref_mem[20] = 64'h5A;
        @(posedge CLK); #1;
        checks++;
        if (core_rstn !== 1'b0) begin errors++; $display("FAIL midrst_still_load: got %b expected 0", core_rstn); end
        @(negedge CLK);
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        bus.sram_rdata = '0;
        test_reset();
        test_load_gating();
        test_preload();
        test_fetch();
        test_byte_write();
        test_contention();
        test_random();
        test_run_gating();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Single-port arbiter and boot sequencer for the chip's 64-bit on-chip SRAM. After reset it owns the SRAM on behalf of a preload (loader) port and holds the core in reset; once the loader signals completion, it releases the core and shares the SRAM between the instruction-fetch and load/store requesters with round-robin arbitration. It sits between `riftCore`'s memory requesters and the SRAM macro, and replaces testbench backdoor preloading with a synthesizable load path.

## Interface
- `AW`, 14, SRAM word-address width (2^14 words)
- `DW`, 64, data width; byte-mask width is DW/8
- `CLK` in 1: clock
- `RSTn` in 1: asynchronous active-low reset
- `ld_valid` in 1: loader write request
- `ld_ready` out 1: loader write accepted this cycle
- `ld_addr` in AW: loader word address
- `ld_data` in DW: loader write data (full-word write)
- `ld_done` in 1: loader finished; sampled only in LOAD
- `core_rstn` out 1: active-low reset to the core; registered
- `if_valid` in 1: fetch read request
- `if_ready` out 1: fetch request granted
- `if_addr` in AW: fetch word address
- `if_rsp_valid` out 1: fetch read data valid
- `if_rsp_data` out DW: fetch read data
- `ls_valid` in 1: LSU request
- `ls_ready` out 1: LSU request granted
- `ls_addr` in AW: LSU word address
- `ls_wen` in 1: 1 = write, 0 = read
- `ls_wstrb` in DW/8: byte write strobes
- `ls_wdata` in DW: LSU write data
- `ls_rsp_valid` out 1: LSU response (read data or write ack)
- `ls_rsp_data` out DW: LSU read data (don't-care on write ack)
- `sram_cs` out 1: SRAM access strobe
- `sram_we` out 1: SRAM write enable
- `sram_wmask` out DW/8: SRAM byte mask
- `sram_addr` out AW: SRAM address
- `sram_wdata` out DW: SRAM write data
- `sram_rdata` in DW: SRAM read data, valid one cycle after a read strobe

## Operation
- Two states: LOAD (reset state) and RUN.
- LOAD: `ld_ready = ld_valid`; an accepted loader write drives `sram_cs=1`, `sram_we=1`, `sram_wmask` all ones. `if_ready = ls_ready = 0`. `core_rstn = 0`.
- LOAD -> RUN when `ld_done=1`. A loader write in the same cycle as `ld_done` is still performed. `core_rstn` rises on the clock edge that enters RUN.
- RUN: `ld_ready = 0`; `ld_done` is ignored. Loader writes are dropped; the loader must not assert `ld_valid` in RUN.
- Arbitration in RUN, one grant per cycle, combinational from the valids:
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester not granted most recently (`last_grant` register, updated on every grant).
  - `last_grant` resets to LSU, so IFU wins the first tie.
- Granted IFU: `sram_cs=1`, `sram_we=0`, `sram_addr=if_addr`.
- Granted LSU: `sram_cs=1`, `sram_we=ls_wen`, `sram_wmask=ls_wstrb` when writing, `sram_addr=ls_addr`, `sram_wdata=ls_wdata`.
- Responses: registered one-cycle pulse per grant, routed to the granted port. `*_rsp_data = sram_rdata`. Responses have no backpressure; requesters always accept them.
- When no access occurs: `sram_cs=0`, `sram_we=0`, `sram_wmask=0`. Address and data are don't-care.
- RUN has no exit except reset. Asserting `RSTn` low in either state returns immediately (asynchronously) to LOAD with `core_rstn=0`. Any response pending at that moment is discarded.

## Timing
- Reset values: state=LOAD, `core_rstn=0`, `if_rsp_valid=0`, `ls_rsp_valid=0`, `last_grant=LSU`.
- All `*_ready` and `sram_*` outputs are combinational from the request inputs and the state. In reset they evaluate to LOAD behaviour.
- Grant in cycle N -> `*_rsp_valid` in cycle N+1, with data sampled from `sram_rdata` in N+1.
- Back-to-back grants are allowed. Sustained throughput is one access per cycle; under continuous contention each requester gets one grant every 2 cycles.
- `ld_done` in cycle N -> `core_rstn=1` from cycle N+1; the first RUN grant is possible in cycle N+1.

## Test plan
- Reset preload: write 0xDEADBEEF_00000013 to addr 0 and 0x1 to addr 0x3FFF via loader, assert `ld_done` -> `core_rstn` rises the next cycle; IFU read of addr 0 returns 0xDEADBEEF_00000013 with `if_rsp_valid` one cycle after the grant.
- Contention: `if_valid` and `ls_valid` held high for 6 cycles -> grants alternate IFU, LSU, IFU, LSU, IFU, LSU; each response pulses exactly once on the correct port.
- Byte write: LSU write `wstrb=0x0F`, data 0x11223344_55667788 to a word preloaded with all ones, then LSU read -> 0xFFFFFFFF_55667788.
- Gating: in LOAD, hold `if_valid=ls_valid=1` -> `if_ready=ls_ready=0` and no SRAM strobes. In RUN, `ld_valid=1` -> `ld_ready=0` and no SRAM write occurs.
- Simultaneous events: `ld_valid` and `ld_done` in the same cycle writing 0xA5 to addr 5 -> write lands; the IFU read of addr 5 afterwards returns 0xA5.
- Reset mid-operation: drop `RSTn` the cycle after an LSU read grant -> `ls_rsp_valid` is suppressed, `core_rstn=0` immediately, state=LOAD, and `ld_ready` follows `ld_valid` again.
